cmp_result_tracker: RTL
=======================

// Module: cmp_result_tracker
// PURPOSE
//  Downstream consumer of the 16-bit magnitude comparator's one-hot gt/lt/eq flags.
//  - On each sample strobe, counts results by class.
//  - Tracks runs of consecutive same-direction results.
//  - Raises a held alarm when a run reaches STREAK_LEN; the alarm stays up until acknowledged.
//  - Sits between the comparator and the status/CPU readout logic.
// PARAMETERS
//  CNT_W       8  width of each result counter; counters saturate at 2**CNT_W-1
//  STREAK_LEN  4  consecutive gt (or lt) samples that trigger the alarm; legal range 2..255
// PORTS
//  clk          in   1      system clock, rising edge
//  n_rst        in   1      synchronous, active-low reset
//  clear        in   1      sync clear: counters, streak, alarm, error; FSM -> IDLE
//  sample       in   1      gt/lt/eq are valid this cycle
//  gt           in   1      comparator a>b
//  lt           in   1      comparator a<b
//  eq           in   1      comparator a==b
//  alarm_ack    in   1      acknowledge and release the alarm
//  gt_count     out  CNT_W  number of gt samples
//  lt_count     out  CNT_W  number of lt samples
//  eq_count     out  CNT_W  number of eq samples
//  streak_alarm out  1      run of STREAK_LEN reached; held until ack/clear
//  alarm_dir    out  1      1 = gt run, 0 = lt run; valid while streak_alarm=1
//  active       out  1      1 once any sample has been accepted since reset/clear
//  onehot_err   out  1      sticky malformed-input flag; present only with CMP_ONEHOT_CHECK_EN
// BEHAVIOUR
//  - Reset (n_rst=0 at clk edge): all counts 0, streak 0, streak_alarm 0, alarm_dir 0, active 0, onehot_err 0, FSM IDLE.
//  - All outputs are registered.
//  - Latency: a sample at edge k is reflected in counts/alarm after edge k; visible in cycle k+1.
//  - Priority: n_rst > clear > alarm_ack > sample.
//    - clear with sample in the same cycle: the sample is discarded.
//  - Decode (default build): eq wins over gt, gt wins over lt. sample with all three flags 0 is ignored entirely.
//  - Counters: +1 on an accepted sample of their class; hold at max (no wrap-around).
//  - Streak counter: 8-bit; dir register holds the last non-eq direction.
//    - eq sample: streak <- 0.
//    - gt/lt sample, same dir as the current run: streak <- streak+1, saturating at STREAK_LEN.
//    - gt/lt sample, opposite dir: streak <- 1, dir <- new dir.
//  - FSM states:
//    - IDLE: wait for first sample. First accepted sample -> TRACK, active=1.
//    - TRACK: a sample making streak == STREAK_LEN -> ALARM; streak_alarm=1 and alarm_dir=dir in the same update.
//    - ALARM: counting continues. streak_alarm and alarm_dir are frozen. A further run does not retrigger.
//      - alarm_ack -> TRACK, streak_alarm=0, streak cleared.
//      - alarm_ack with sample in the same cycle: the sample is counted; streak restarts from it (1 for gt/lt, 0 for eq).
//      - A new alarm needs STREAK_LEN fresh samples after the ack.
//    - alarm_ack outside ALARM has no effect.
//  - clear in any state -> IDLE, active=0.
//  - n_rst mid-run: everything returns to reset values on that edge. No partial update.
// CONFIGURATION
//  CMP_ONEHOT_CHECK_EN defined:
//    - sample with gt+lt+eq != 1 (including all-zero) is dropped: no count, streak and FSM unchanged.
//    - onehot_err <- 1 and stays set until clear or reset.
//  CMP_ONEHOT_CHECK_EN undefined:
//    - onehot_err port does not exist.
//    - Priority decode as above.
// TESTING  (CNT_W=8, STREAK_LEN=4)
//  - Reset: hold n_rst=0 two cycles -> all counts 0, streak_alarm=0, active=0.
//  - 3 gt, 1 eq, 3 gt samples -> gt_count=6, eq_count=1, streak_alarm=0.
//  - 4 gt samples -> streak_alarm=1, alarm_dir=1 in the cycle after the 4th.
//    - Next, alarm_ack together with an lt sample -> alarm=0, lt_count=1, streak=1.
//    - 3 more lt -> alarm=1, alarm_dir=0.
//  - 300 eq samples -> eq_count saturates at 255.
//    - Then clear together with a gt sample -> all counts 0, active=0.
//  - With the macro: sample with gt=lt=1 -> no count change, onehot_err=1, and it stays 1 through valid samples.
//    - Without the macro, same stimulus -> gt_count+1.
//  - n_rst=0 while streak_alarm=1 -> alarm and counts 0 on the next edge.

Source files
------------

// File: rtl/cmp_result_tracker.sv
// cmp_result_tracker
// Consumes the one-hot gt/lt/eq flags of a 16-bit magnitude comparator.
// Counts results by class with saturating counters, tracks runs of
// same-direction results and raises a held alarm when a run reaches
// STREAK_LEN. The alarm stays up until alarm_ack or clear.
// Optional build macro: CMP_ONEHOT_CHECK_EN. It drops malformed samples
// and adds the sticky onehot_err output.
module cmp_result_tracker #(
  parameter int CNT_W      = 8,
  parameter int STREAK_LEN = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             sample,
  input  logic             gt,
  input  logic             lt,
  input  logic             eq,
  input  logic             alarm_ack,
  output logic [CNT_W-1:0] gt_count,
  output logic [CNT_W-1:0] lt_count,
  output logic [CNT_W-1:0] eq_count,
  output logic             streak_alarm,
  output logic             alarm_dir,
`ifdef CMP_ONEHOT_CHECK_EN
  output logic             active,
  output logic             onehot_err
`else
  output logic             active
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]       STREAK_MAX = 8'(STREAK_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ALARM = 2'd2
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] gt_count_r;
  logic [CNT_W-1:0] lt_count_r;
  logic [CNT_W-1:0] eq_count_r;
  logic [7:0]       streak_r;
  logic             dir_r;
  logic             alarm_r;
  logic             alarm_dir_r;
  logic             active_r;
`ifdef CMP_ONEHOT_CHECK_EN
  logic             onehot_err_r;
  logic             bad_s;
`endif

  logic       accept_s;
  logic       sel_gt_s;
  logic       sel_lt_s;
  logic       sel_eq_s;
  logic [7:0] run_next_s;
  logic [7:0] restart_s;
  logic       dir_next_s;

  // Saturating increment for the result counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

`ifdef CMP_ONEHOT_CHECK_EN
  // True when exactly one of the three comparator flags is set.
  function automatic logic is_onehot3(input logic [2:0] f);
    case (f)
      3'b001:  return 1'b1;
      3'b010:  return 1'b1;
      3'b100:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
`endif

  // Decode the comparator flags and compute the streak that an accepted sample would produce.
  always_comb begin
    accept_s   = 1'b0;
    sel_gt_s   = 1'b0;
    sel_lt_s   = 1'b0;
    sel_eq_s   = 1'b0;
`ifdef CMP_ONEHOT_CHECK_EN
    bad_s      = 1'b0;
    if (sample) begin
      if (is_onehot3({gt, lt, eq})) begin
        accept_s = 1'b1;
        sel_gt_s = gt;
        sel_lt_s = lt;
        sel_eq_s = eq;
      end else begin
        bad_s = 1'b1;
      end
    end else begin
      accept_s = 1'b0;
    end
`else
    // eq has priority over gt, gt over lt; all-zero flags are ignored
    if (sample && (gt || lt || eq)) begin
      accept_s = 1'b1;
      sel_eq_s = eq;
      sel_gt_s = gt && !eq;
      sel_lt_s = lt && !gt && !eq;
    end else begin
      accept_s = 1'b0;
    end
`endif
    dir_next_s = dir_r;
    run_next_s = streak_r;
    restart_s  = 8'd0;
    if (sel_eq_s) begin
      run_next_s = 8'd0;
    end else if (sel_gt_s || sel_lt_s) begin
      dir_next_s = sel_gt_s;
      restart_s  = 8'd1;
      if (sel_gt_s == dir_r) begin
        run_next_s = (streak_r >= STREAK_MAX) ? STREAK_MAX : streak_r + 8'd1;
      end else begin
        run_next_s = 8'd1;
      end
    end else begin
      run_next_s = streak_r;
    end
  end

  // Tracker state machine: counters, streak, alarm and activity flags.
  always_ff @(posedge clk) begin
    if (!n_rst || clear) begin
      state_r      <= IDLE;
      gt_count_r   <= CNT_ZERO;
      lt_count_r   <= CNT_ZERO;
      eq_count_r   <= CNT_ZERO;
      streak_r     <= 8'd0;
      dir_r        <= 1'b0;
      alarm_r      <= 1'b0;
      alarm_dir_r  <= 1'b0;
      active_r     <= 1'b0;
`ifdef CMP_ONEHOT_CHECK_EN
      onehot_err_r <= 1'b0;
`endif
    end else begin
`ifdef CMP_ONEHOT_CHECK_EN
      if (bad_s) begin
        onehot_err_r <= 1'b1;
      end
`endif
      if (accept_s) begin
        if (sel_gt_s) gt_count_r <= sat_inc(gt_count_r);
        if (sel_lt_s) lt_count_r <= sat_inc(lt_count_r);
        if (sel_eq_s) eq_count_r <= sat_inc(eq_count_r);
      end
      case (state_r)
        IDLE, TRACK: begin
          if (accept_s) begin
            active_r <= 1'b1;
            streak_r <= run_next_s;
            dir_r    <= dir_next_s;
            if (run_next_s == STREAK_MAX) begin
              state_r     <= ALARM;
              alarm_r     <= 1'b1;
              alarm_dir_r <= dir_next_s;
            end else begin
              state_r <= TRACK;
            end
          end
        end
        ALARM: begin
          if (alarm_ack) begin
            // release; the streak restarts from the same-cycle sample, if any
            state_r <= TRACK;
            alarm_r <= 1'b0;
            if (accept_s) begin
              streak_r <= restart_s;
              dir_r    <= dir_next_s;
            end else begin
              streak_r <= 8'd0;
            end
          end else if (accept_s) begin
            streak_r <= run_next_s;
            dir_r    <= dir_next_s;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign gt_count     = gt_count_r;
  assign lt_count     = lt_count_r;
  assign eq_count     = eq_count_r;
  assign streak_alarm = alarm_r;
  assign alarm_dir    = alarm_dir_r;
  assign active       = active_r;
`ifdef CMP_ONEHOT_CHECK_EN
  assign onehot_err   = onehot_err_r;
`endif

endmodule
